// File: rtl/pwm_fade_ctrl_if.sv
// Control/config/status bundle between the fade sequencer and its controller.
// master = config/control logic, slave = pwm_fade_ctrl.
interface pwm_fade_ctrl_if;
  logic       enable;
  logic       start;
  logic       stop;
  logic [7:0] min_duty;
  logic [7:0] max_duty;
  logic [7:0] step;
  logic [7:0] hold_periods;
  logic [7:0] repeat_count;
  logic [7:0] duty_cycle;
  logic       period_tick;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output enable, start, stop, min_duty, max_duty, step, hold_periods, repeat_count,
    input  duty_cycle, period_tick, busy, done, err
  );

  modport slave (
    input  enable, start, stop, min_duty, max_duty, step, hold_periods, repeat_count,
    output duty_cycle, period_tick, busy, done, err
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Breathing-pattern sequencer for the pwm duty_cycle input: ramp up, hold, ramp down,
// hold, repeated N times or forever. Duty only changes on PWM period boundaries.
module pwm_fade_ctrl #(
  parameter int unsigned PERIOD_CLKS = 256
) (
  input logic           clk,
  input logic           reset,
  pwm_fade_ctrl_if.slave bus
);
  localparam int unsigned    CW   = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [CW-1:0]  LAST = CW'(PERIOD_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HI,
    RAMP_DOWN,
    HOLD_LO
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    max_q, max_d;
  logic [7:0]    step_q, step_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    hold_cnt_q, hold_cnt_d;
  logic [7:0]    rep_cnt_q, rep_cnt_d;
  logic          forever_q, forever_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          busy;
  logic          tick;
  logic [8:0]    up_sum;
  logic [8:0]    down_floor;

  assign busy       = (state_q != IDLE);
  assign tick       = busy && bus.enable && (cnt_q == LAST);
  assign up_sum     = {1'b0, duty_q} + {1'b0, step_q};
  assign down_floor = {1'b0, min_q} + {1'b0, step_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    duty_d     = duty_q;
    min_d      = min_q;
    max_d      = max_q;
    step_d     = step_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    forever_d  = forever_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (busy && bus.enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        // enable=0 freezes the FSM, so a start request is only honoured while running
        if (bus.start && !bus.stop && bus.enable) begin
          if (bus.min_duty > bus.max_duty) begin
            err_d = 1'b1;
          end else begin
            min_d     = bus.min_duty;
            max_d     = bus.max_duty;
            step_d    = (bus.step == '0) ? 8'd1 : bus.step;
            hold_d    = bus.hold_periods;
            rep_cnt_d = bus.repeat_count;
            forever_d = (bus.repeat_count == '0);
            duty_d    = bus.min_duty;
            cnt_d     = '0;
            state_d   = RAMP_UP;
          end
        end
      end

      RAMP_UP: begin
        if (tick) begin
          if (up_sum >= {1'b0, max_q}) begin
            duty_d     = max_q;
            hold_cnt_d = hold_q;
            state_d    = HOLD_HI;
          end else begin
            duty_d = up_sum[7:0];
          end
        end
      end

      HOLD_HI: begin
        if (tick) begin
          if (hold_cnt_q == '0) state_d = RAMP_DOWN;
          else                  hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end

      RAMP_DOWN: begin
        // comparing against min+step in 9 bits keeps duty-step from dropping below min
        if (tick) begin
          if ({1'b0, duty_q} < down_floor) begin
            duty_d     = min_q;
            hold_cnt_d = hold_q;
            state_d    = HOLD_LO;
          end else begin
            duty_d = duty_q - step_q;
          end
        end
      end

      HOLD_LO: begin
        if (tick) begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
          end else if (forever_q) begin
            state_d = RAMP_UP;
          end else if (rep_cnt_q == 8'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rep_cnt_d = rep_cnt_q - 8'd1;
            state_d   = RAMP_UP;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // abort overrides everything, independent of enable
    if (busy && bus.stop) begin
      state_d = IDLE;
      duty_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      duty_q     <= '0;
      min_q      <= '0;
      max_q      <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      forever_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      min_q      <= min_d;
      max_q      <= max_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      forever_q  <= forever_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.duty_cycle  = duty_q;
  assign bus.period_tick = tick;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl with an 8-clock PWM period: table of fade
// configurations with per-tick expected duty in a scoreboard queue, plus hand sequences.
module tb_pwm_fade_ctrl;
  localparam int unsigned P = 8;

  logic clk = 1'b0;
  logic reset;

  pwm_fade_ctrl_if bus ();

  pwm_fade_ctrl #(.PERIOD_CLKS(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] st;
    logic [7:0] hd;
    logic [7:0] rp;
    logic [7:0] off;
    logic [7:0] len;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] seq_rom [47];
  logic [7:0] exp_q [$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] st,
                         input logic [7:0] hd, input logic [7:0] rp);
    bus.min_duty     = mn;
    bus.max_duty     = mx;
    bus.step         = st;
    bus.hold_periods = hd;
    bus.repeat_count = rp;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step_clk();
    bus.start = 1'b0;
  endtask

  // Consume the scoreboard queue, one entry per period tick, starting right after a start edge.
  task automatic run_seq(input string tag, input bit want_done);
    int  since   = 0;
    int  budget  = exp_q.size() * P * 4 + 50;
    bit  was_tick;
    while (exp_q.size() > 0 && budget > 0) begin
      was_tick = bus.period_tick;
      step_clk();
      budget--;
      since++;
      if (was_tick) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check({tag, " duty"}, bus.duty_cycle, e);
        check({tag, " tick spacing"}, since, P);
        since = 0;
        if (exp_q.size() == 0 && want_done) begin
          check({tag, " done at end"}, bus.done, 1);
          check({tag, " busy after done"}, bus.busy, 0);
        end else begin
          check({tag, " busy mid-run"}, bus.busy, 1);
          check({tag, " no early done"}, bus.done, 0);
        end
      end else if (bus.done) begin
        check({tag, " done off-tick"}, bus.done, 0);
      end
    end
    check({tag, " sequence timeout"}, exp_q.size(), 0);
  endtask

  initial begin
    seq_rom = '{
      16, 32, 48, 64, 64, 64, 48, 32, 16, 0, 0, 0, 0,
      110, 210, 250, 250, 150, 50, 10, 10,
      50, 50, 50, 50,
      4, 5, 5, 4, 3, 3, 3, 4, 5, 5, 4, 3, 3, 3,
      255, 255, 255, 255, 200, 200, 200, 200
    };
    //            min    max    step   hold  rep   off    len
    tbl[0] = '{8'd0,   8'd64,  8'd16,  8'd1, 8'd1, 8'd0,  8'd13};
    tbl[1] = '{8'd10,  8'd250, 8'd100, 8'd0, 8'd1, 8'd13, 8'd8};
    tbl[2] = '{8'd50,  8'd50,  8'd7,   8'd0, 8'd1, 8'd21, 8'd4};
    tbl[3] = '{8'd3,   8'd5,   8'd0,   8'd0, 8'd2, 8'd25, 8'd14};
    tbl[4] = '{8'd200, 8'd255, 8'd255, 8'd2, 8'd1, 8'd39, 8'd8};

    bus.enable = 1'b1;
    bus.stop   = 1'b0;
    set_cfg(8'd0, 8'd64, 8'd16, 8'd1, 8'd1);

    // Reset held for two clocks with start asserted
    reset     = 1'b1;
    bus.start = 1'b1;
    step_clk();
    step_clk();
    check("reset duty", bus.duty_cycle, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset err", bus.err, 0);
    check("reset tick", bus.period_tick, 0);
    reset     = 1'b0;
    bus.start = 1'b0;
    step_clk();
    check("idle after reset", bus.busy, 0);

    // Table-driven fade sequences
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      set_cfg(tbl[i].mn, tbl[i].mx, tbl[i].st, tbl[i].hd, tbl[i].rp);
      for (int k = 0; k < int'(tbl[i].len); k++) exp_q.push_back(seq_rom[int'(tbl[i].off) + k]);
      pulse_start();
      check({tag, " busy on start"}, bus.busy, 1);
      check({tag, " duty=min on start"}, bus.duty_cycle, tbl[i].mn);
      run_seq(tag, 1'b1);
      step_clk();
      check({tag, " done one cycle"}, bus.done, 0);
      check({tag, " duty holds min"}, bus.duty_cycle, tbl[i].mn);
    end

    // Abort mid-ramp, then start+stop together
    begin
      bit seen_done = 0;
      set_cfg(8'd0, 8'd64, 8'd16, 8'd1, 8'd1);
      pulse_start();
      for (int c = 0; c < 12; c++) step_clk();
      check("abort pre duty", bus.duty_cycle, 16);
      bus.stop = 1'b1;
      step_clk();
      bus.stop = 1'b0;
      check("abort duty", bus.duty_cycle, 0);
      check("abort busy", bus.busy, 0);
      for (int c = 0; c < 120; c++) begin
        step_clk();
        if (bus.done) seen_done = 1;
      end
      check("abort no done", seen_done, 0);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step_clk();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("start+stop busy", bus.busy, 0);
      check("start+stop err", bus.err, 0);
      step_clk();
      check("start+stop stays idle", bus.busy, 0);
    end

    // Rejected start
    set_cfg(8'd100, 8'd50, 8'd1, 8'd0, 8'd1);
    pulse_start();
    check("err pulse", bus.err, 1);
    check("err busy", bus.busy, 0);
    step_clk();
    check("err one cycle", bus.err, 0);

    // Forever mode: 5 full cycles of 8,8,0,0,0 with no done
    set_cfg(8'd0, 8'd8, 8'd8, 8'd0, 8'd0);
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back(8); exp_q.push_back(8);
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    end
    pulse_start();
    run_seq("forever", 1'b0);
    check("forever still busy", bus.busy, 1);
    bus.stop = 1'b1;
    step_clk();
    bus.stop = 1'b0;
    check("forever stopped", bus.busy, 0);

    // Enable gating: 5-clock freeze mid-period delays the first tick by 5 clocks
    begin
      int  clocks = 3;
      int  budget = 40;
      bit  was_tick = 0;
      set_cfg(8'd0, 8'd64, 8'd16, 8'd1, 8'd1);
      pulse_start();
      for (int c = 0; c < 3; c++) step_clk();
      bus.enable = 1'b0;
      for (int c = 0; c < 5; c++) begin
        step_clk();
        clocks++;
        check("gated tick low", bus.period_tick, 0);
        check("gated duty frozen", bus.duty_cycle, 0);
      end
      check("gated busy held", bus.busy, 1);
      bus.enable = 1'b1;
      while (!was_tick && budget > 0) begin
        was_tick = bus.period_tick;
        step_clk();
        clocks++;
        budget--;
      end
      check("gated tick seen", was_tick, 1);
      check("gated tick delay", clocks, P + 5);
      check("gated duty after tick", bus.duty_cycle, 16);
      bus.stop = 1'b1;
      step_clk();
      bus.stop = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
